// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding rename. Dispatch pops
// the head tag; commit and revert walk-back push freed tags back in.
module phys_reg_free_list #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
    parameter int PT            = $clog2(NUM_PHYS_REGS),
    parameter int PW            = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          dequeue_valid,
    output logic [PT-1:0] dequeue_phys_reg_tag,
    output logic          free_list_empty,
    output logic [PW-1:0] free_count,
    input  logic          revert_free_valid,
    input  logic [PT-1:0] revert_free_phys_reg_tag,
    input  logic          commit_free_valid,
    input  logic [PT-1:0] commit_free_phys_reg_tag,
    output logic          error_overflow,
    output logic          error_underflow
);

    localparam int IW = PW - 1;
    localparam int SW = PW + 1;

    logic [PT-1:0] entries_q [DEPTH];
    logic [PT-1:0] entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;

    logic [PW-1:0] count;
    logic          empty;
    logic          deq_ok;
    logic          rev_ok;
    logic          com_ok;
    logic [SW-1:0] slots;
    logic [IW-1:0] rev_idx;
    logic [IW-1:0] com_idx;

    // Outputs depend on registered state only; nothing bypasses from the inputs.
    always_comb begin
        count                = tail_q - head_q;
        empty                = (count == '0);
        dequeue_phys_reg_tag = entries_q[head_q[IW-1:0]];
        free_count           = count;
        free_list_empty      = empty;
        error_overflow       = err_ovf_q;
        error_underflow      = err_unf_q;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;

        deq_ok = dequeue_valid & ~empty;

        // Free slots this edge: a same-cycle dequeue releases one for enqueue.
        slots  = SW'(DEPTH) - {1'b0, count} + SW'(deq_ok);
        rev_ok = revert_free_valid & (slots != '0);
        com_ok = commit_free_valid & (slots > SW'(rev_ok));

        // Revert takes the first slot; commit lands behind it when both go in.
        rev_idx = tail_q[IW-1:0];
        com_idx = tail_q[IW-1:0] + IW'(rev_ok);

        if (rev_ok) begin
            entries_d[rev_idx] = revert_free_phys_reg_tag;
        end
        if (com_ok) begin
            entries_d[com_idx] = commit_free_phys_reg_tag;
        end

        head_d = head_q + PW'(deq_ok);
        tail_d = tail_q + PW'(rev_ok) + PW'(com_ok);

        if ((revert_free_valid & ~rev_ok) | (commit_free_valid & ~com_ok)) begin
            err_ovf_d = 1'b1;
        end
        if (dequeue_valid & empty) begin
            err_unf_d = 1'b1;
        end
    end

    // Reset leaves the list full with the non-architectural tags in order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= PT'(NUM_ARCH_REGS + i);
            end
            head_q    <= '0;
            tail_q    <= PW'(DEPTH);
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset, drain, dual free, simultaneous
// dequeue/enqueue at empty and full, overflow drops, wrap-around, async reset.
module tb_phys_reg_free_list;

    logic       CLK;
    logic       RST;
    logic       dequeue_valid;
    logic [5:0] dequeue_phys_reg_tag;
    logic       free_list_empty;
    logic [5:0] free_count;
    logic       revert_free_valid;
    logic [5:0] revert_free_phys_reg_tag;
    logic       commit_free_valid;
    logic [5:0] commit_free_phys_reg_tag;
    logic       error_overflow;
    logic       error_underflow;

    int vectors;
    int miscompares;

    phys_reg_free_list dut (
        .CLK                      (CLK),
        .RST                      (RST),
        .dequeue_valid            (dequeue_valid),
        .dequeue_phys_reg_tag     (dequeue_phys_reg_tag),
        .free_list_empty          (free_list_empty),
        .free_count               (free_count),
        .revert_free_valid        (revert_free_valid),
        .revert_free_phys_reg_tag (revert_free_phys_reg_tag),
        .commit_free_valid        (commit_free_valid),
        .commit_free_phys_reg_tag (commit_free_phys_reg_tag),
        .error_overflow           (error_overflow),
        .error_underflow          (error_underflow)
    );

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic idle_inputs();
        dequeue_valid            = 1'b0;
        revert_free_valid        = 1'b0;
        revert_free_phys_reg_tag = '0;
        commit_free_valid        = 1'b0;
        commit_free_phys_reg_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
    endtask

    // Advance one clock with the current inputs, then settle past the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int n);
        dequeue_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        dequeue_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd32) begin
            miscompares++;
            $display("FAIL reset_tag: got %0d expected 32", dequeue_phys_reg_tag);
        end
        vectors++;
        if (free_count !== 6'd32) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 32", free_count);
        end
        vectors++;
        if ({free_list_empty, error_overflow, error_underflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got empty/ovf/unf=%b expected 000",
                     {free_list_empty, error_overflow, error_underflow});
        end
    endtask

    task automatic test_drain();
        do_reset();
        dequeue_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (dequeue_phys_reg_tag !== 6'(32 + i)) begin
                miscompares++;
                $display("FAIL drain_tag[%0d]: got %0d expected %0d", i, dequeue_phys_reg_tag, 32 + i);
            end
            step();
        end
        dequeue_valid = 1'b0;
        #1;
        vectors++;
        if (free_list_empty !== 1'b1 || free_count !== 6'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got empty=%b count=%0d expected empty=1 count=0",
                     free_list_empty, free_count);
        end
        vectors++;
        if (error_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_no_unf: got %b expected 0", error_underflow);
        end
        dequeue_valid = 1'b1;
        step();
        dequeue_valid = 1'b0;
        #1;
        vectors++;
        if (error_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_flag: got %b expected 1", error_underflow);
        end
        vectors++;
        if (free_count !== 6'd0 || dequeue_phys_reg_tag !== 6'd32) begin
            miscompares++;
            $display("FAIL underflow_hold: got count=%0d tag=%0d expected count=0 tag=32",
                     free_count, dequeue_phys_reg_tag);
        end
    endtask

    task automatic test_dual_free_empty();
        do_reset();
        drain(32);
        revert_free_valid        = 1'b1;
        revert_free_phys_reg_tag = 6'd63;
        commit_free_valid        = 1'b1;
        commit_free_phys_reg_tag = 6'd5;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (free_count !== 6'd2 || dequeue_phys_reg_tag !== 6'd63) begin
            miscompares++;
            $display("FAIL dual_free: got count=%0d tag=%0d expected count=2 tag=63",
                     free_count, dequeue_phys_reg_tag);
        end
        vectors++;
        if (free_list_empty !== 1'b0 || error_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL dual_free_flags: got empty=%b ovf=%b expected 0 0",
                     free_list_empty, error_overflow);
        end
        drain(1);
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd5 || free_count !== 6'd1) begin
            miscompares++;
            $display("FAIL dual_free_second: got tag=%0d count=%0d expected tag=5 count=1",
                     dequeue_phys_reg_tag, free_count);
        end
    endtask

    task automatic test_deq_enq_empty();
        do_reset();
        drain(32);
        dequeue_valid            = 1'b1;
        commit_free_valid        = 1'b1;
        commit_free_phys_reg_tag = 6'd40;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (error_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_deq_enq_unf: got %b expected 1", error_underflow);
        end
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd40 || free_count !== 6'd1) begin
            miscompares++;
            $display("FAIL empty_deq_enq: got tag=%0d count=%0d expected tag=40 count=1",
                     dequeue_phys_reg_tag, free_count);
        end
    endtask

    task automatic test_full_overflow();
        // Full plus dequeue: one slot, revert wins, commit dropped.
        do_reset();
        dequeue_valid            = 1'b1;
        revert_free_valid        = 1'b1;
        revert_free_phys_reg_tag = 6'd7;
        commit_free_valid        = 1'b1;
        commit_free_phys_reg_tag = 6'd9;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (error_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ovf_flag: got %b expected 1", error_overflow);
        end
        vectors++;
        if (free_count !== 6'd32 || dequeue_phys_reg_tag !== 6'd33) begin
            miscompares++;
            $display("FAIL full_ovf_state: got count=%0d tag=%0d expected count=32 tag=33",
                     free_count, dequeue_phys_reg_tag);
        end
        drain(31);
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd7 || free_count !== 6'd1) begin
            miscompares++;
            $display("FAIL full_ovf_revert_kept: got tag=%0d count=%0d expected tag=7 count=1",
                     dequeue_phys_reg_tag, free_count);
        end
        // Full without dequeue: no slot, the lone commit is dropped.
        do_reset();
        commit_free_valid        = 1'b1;
        commit_free_phys_reg_tag = 6'd3;
        step();
        idle_inputs();
        #1;
        vectors++;
        if (error_overflow !== 1'b1 || free_count !== 6'd32 || dequeue_phys_reg_tag !== 6'd32) begin
            miscompares++;
            $display("FAIL full_drop: got ovf=%b count=%0d tag=%0d expected ovf=1 count=32 tag=32",
                     error_overflow, free_count, dequeue_phys_reg_tag);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drain(20);
        for (int i = 0; i < 20; i++) begin
            commit_free_valid        = 1'b1;
            commit_free_phys_reg_tag = 6'(i);
            step();
        end
        idle_inputs();
        #1;
        vectors++;
        if (free_count !== 6'd32 || error_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_refill: got count=%0d ovf=%b expected count=32 ovf=0",
                     free_count, error_overflow);
        end
        dequeue_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (dequeue_phys_reg_tag !== 6'(i < 12 ? 52 + i : i - 12)) begin
                miscompares++;
                $display("FAIL wrap_tag[%0d]: got %0d expected %0d", i, dequeue_phys_reg_tag,
                         i < 12 ? 52 + i : i - 12);
            end
            step();
        end
        dequeue_valid = 1'b0;
        #1;
        vectors++;
        if (free_list_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_empty: got %b expected 1", free_list_empty);
        end
        // Make the underflow flag sticky, then hit reset mid-cycle.
        dequeue_valid     = 1'b1;
        commit_free_valid = 1'b1;
        commit_free_phys_reg_tag = 6'd11;
        step();
        #2;
        RST = 1'b1;
        #1;
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd32 || free_count !== 6'd32) begin
            miscompares++;
            $display("FAIL async_reset_state: got tag=%0d count=%0d expected tag=32 count=32",
                     dequeue_phys_reg_tag, free_count);
        end
        vectors++;
        if ({free_list_empty, error_overflow, error_underflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset_flags: got empty/ovf/unf=%b expected 000",
                     {free_list_empty, error_overflow, error_underflow});
        end
        idle_inputs();
        step();
        RST = 1'b0;
        step();
        vectors++;
        if (dequeue_phys_reg_tag !== 6'd32 || free_count !== 6'd32 ||
            {free_list_empty, error_overflow, error_underflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got tag=%0d count=%0d flags=%b expected 32 32 000",
                     dequeue_phys_reg_tag, free_count,
                     {free_list_empty, error_overflow, error_underflow});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b1;
        idle_inputs();
        test_reset();
        test_drain();
        test_dual_free_empty();
        test_deq_enq_empty();
        test_full_overflow();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular FIFO of free physical register tags that sits directly upstream of the physical register map table. Dispatch pops the head tag and drives it as the rename destination phys reg into the map table. Commit returns the freed old (safe) mapping. Revert walk-back returns the speculated mapping that the map table just undid. The block also exposes an occupancy count and an empty flag so the core controller can stall dispatch.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; phys tags 0..NUM_ARCH_REGS-1 are mapped at reset and never start in the list.
NUM_PHYS_REGS, 64, total physical registers; phys tag width PT = log2(NUM_PHYS_REGS).
DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (32), FIFO entries; must be a power of 2; pointer width PW = log2(DEPTH)+1 (MSB is the wrap bit).

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
dequeue_valid  in  1  rename consumes the head tag this cycle
dequeue_phys_reg_tag  out  PT  current head tag (combinational from state)
free_list_empty  out  1  no free tag available; dispatch must stall
free_count  out  PW  number of valid entries, 0..DEPTH
revert_free_valid  in  1  revert returns a speculated tag
revert_free_phys_reg_tag  in  PT  tag returned by revert
commit_free_valid  in  1  commit returns the old safe tag
commit_free_phys_reg_tag  in  PT  tag returned by commit
error_overflow  out  1  sticky: an enqueue was dropped because the list was full
error_underflow  out  1  sticky: dequeue_valid was asserted while empty

Behaviour:
- Reset (asynchronous, RST=1):
  - entries[i] = NUM_ARCH_REGS+i for i in 0..DEPTH-1.
  - head=0; tail = DEPTH (wrap bit set, index 0), so the list is full.
  - free_count=DEPTH; free_list_empty=0; dequeue_phys_reg_tag=NUM_ARCH_REGS; both error flags 0.
  - RST asserted mid-operation discards all in-flight state; the next cycle after deassertion is identical to post-reset.
- Combinational outputs, all from registered state only (no bypass):
  - dequeue_phys_reg_tag = entries[head index].
  - free_count = tail - head, mod 2^PW.
  - free_list_empty = (free_count==0).
- Dequeue, on the clock edge:
  - dequeue_valid & ~free_list_empty advances head by 1. Latency 0: the tag is valid in the same cycle as the request.
  - dequeue_valid & free_list_empty is ignored (head holds) and sets error_underflow.
- Enqueue, on the clock edge:
  - Zero, one or two tags may enqueue per cycle.
  - Revert has slot priority: the revert tag is written at entries[tail]. The commit tag is written at entries[tail+1] if revert is also valid, otherwise at entries[tail].
  - tail advances by the number of accepted tags.
- Capacity is checked against the current (pre-edge) count plus accepted enqueues, minus an accepted dequeue:
  - A dequeue in the same cycle frees one slot for enqueue.
  - If only one slot is available and both ports are valid, the revert tag is accepted, the commit tag is dropped, and error_overflow is set.
  - If no slot is available, all valid enqueues are dropped and error_overflow is set.
- Simultaneous events:
  - Dequeue + enqueue while empty: the dequeue is rejected. The enqueued tag becomes visible at the head the next cycle.
  - Dequeue + enqueue while full: both succeed; the count is unchanged.
- Wrap-around: pointers increment modulo 2^PW. The index is the low log2(DEPTH) bits. Full is when the indices are equal and the wrap bits differ.
- Error flags are sticky until RST. They have no effect on the datapath beyond the drops and rejects described above.
- The block never checks tags for duplicates or range.

Test Plan:
1. Reset, then hold all inputs low: dequeue_phys_reg_tag=32, free_count=32, free_list_empty=0, error flags 0.
2. dequeue_valid held high for 32 cycles: tags 32,33,...,63 are observed in order. After that, free_list_empty=1 and free_count=0. One more dequeue sets error_underflow=1 and head does not move.
3. From empty, revert_free(tag 63) and commit_free(tag 5) in the same cycle: next cycle free_count=2 and head tag=63. After one dequeue, head tag=5.
4. From empty, dequeue_valid with commit_free(tag 40) in the same cycle: the dequeue is rejected and error_underflow=1. Next cycle dequeue_phys_reg_tag=40 and free_count=1.
5. From full (post-reset), dequeue plus both frees (tags 7, 9) in one cycle: revert tag 7 is accepted, commit tag 9 is dropped, error_overflow=1, free_count stays 32.
6. Wrap test: 20 dequeues, then 20 commit frees of tags 0..19, then 32 dequeues. Observed sequence is 52..63 then 0..19, and free_list_empty=1 at the end. Finally assert RST mid-stream: all state returns to the values in scenario 1 immediately, asynchronously.
